// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake and
// hands instruction + PC+4 to IF/ID, honouring stall and branch/jump redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        valid_out,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        flush_out,
    output logic        misalign_err
);

    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] READY = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] addr_q;
    logic [31:0] ibuf;
    logic [31:0] pc_out_q;
    logic [31:0] target;

    assign target    = {redirect_pc[31:2], 2'b00};
    assign imem_req  = (state == FETCH) || (state == DRAIN);
    // DRAIN keeps presenting the old address so the abandoned request completes cleanly
    assign imem_addr = (state == DRAIN) ? addr_q : pc;
    assign valid_out = (state == READY);
    assign instr_out = ibuf;
    assign pc_out    = pc_out_q;
    assign flush_out = redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            addr_q   <= RESET_PC;
            ibuf     <= 32'h0;
            pc_out_q <= RESET_PC + 32'd4;
        end else begin
            case (state)
                BOOT: state <= FETCH;
                FETCH: begin
                    addr_q <= pc;
                    if (redirect) begin
                        pc    <= target;
                        state <= imem_ack ? FETCH : DRAIN;
                    end else if (imem_ack) begin
                        ibuf     <= imem_rdata;
                        pc_out_q <= pc + 32'd4;
                        state    <= READY;
                    end
                end
                READY: begin
                    if (redirect) begin
                        pc    <= target;
                        state <= FETCH;
                    end else if (!stall) begin
                        pc    <= pc + 32'd4;
                        state <= FETCH;
                    end
                end
                default: begin
                    if (redirect) begin
                        pc <= target;
                    end
                    if (imem_ack) begin
                        state <= FETCH;
                    end
                end
            endcase
        end
    end

    // Redirects are ignored in BOOT, so they cannot flag a misalignment there either
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err <= 1'b0;
        end else if ((state != BOOT) && redirect && (redirect_pc[1:0] != 2'b00)) begin
            misalign_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios followed by randomized
// stall/redirect/wait-state traffic checked against an architectural PC-stream model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        valid_out;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        flush_out;
    logic        misalign_err;

    int checks = 0;
    int passes = 0;
    int captures = 0;
    bit mon_en = 1'b0;

    // Architectural model: queue of instruction addresses IF/ID should receive next
    logic [31:0] expq[$];
    logic [31:0] exp_pc;
    bit          mis_cur;
    bit          mis_pend;

    bit          mem_busy;
    int          mem_wait;
    int          wait_min = 0;
    int          wait_max = 0;
    logic [31:0] mem_addr;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .valid_out(valid_out),
        .instr_out(instr_out), .pc_out(pc_out), .flush_out(flush_out),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        else passes++;
    endtask

    // Drives one cycle of inputs at the falling edge, plays memory and advances the model
    task automatic applyStimulus(input logic st, input logic rd, input logic [31:0] rpc);
        @(negedge clk);
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        mis_cur     = mis_pend;
        if (imem_req) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_wait = $urandom_range(wait_max, wait_min);
                mem_addr = imem_addr;
            end else begin
                checkOutput("addr_stable", imem_addr, mem_addr);
            end
            if (mem_wait == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                mem_busy   = 1'b0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                mem_wait--;
            end
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
        end
        if (rd) begin
            if (rpc[1:0] != 2'b00) mis_pend = 1'b1;
            expq.delete();
            exp_pc = {rpc[31:2], 2'b00};
            expq.push_back(exp_pc);
        end else if (valid_out && !st) begin
            exp_pc = exp_pc + 32'd4;
            expq.push_back(exp_pc);
        end
    endtask

    task automatic resetDut();
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_ack = 1'b0; mem_busy = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_imem_req", imem_req, 0);
        checkOutput("rst_valid", valid_out, 0);
        checkOutput("rst_instr", instr_out, 32'h0);
        checkOutput("rst_pc_out", pc_out, 32'h4);
        checkOutput("rst_misalign", misalign_err, 0);
        expq.delete();
        exp_pc = 32'h0;
        expq.push_back(exp_pc);
        mis_cur = 1'b0;
        mis_pend = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("boot_imem_req", imem_req, 0);
    endtask

    // Holds stall so that the first instruction to appear stays presented
    task automatic waitValid(input logic [31:0] addr);
        bit found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0);
            #1;
            if (valid_out) found = 1'b1;
        end
        if (!found) begin
            checks++;
            $display("[TB] FAIL wait_valid: no valid_out within 30 cycles, required instr at %h", addr);
        end else begin
            checkOutput("held_instr", instr_out, mem_word(addr));
            checkOutput("held_pc_out", pc_out, addr + 32'd4);
        end
    endtask

    // Monitor: flush/misalign every cycle, scoreboard pop on each IF/ID capture
    initial begin
        logic [31:0] a;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && mon_en) begin
                checkOutput("flush_out", flush_out, redirect);
                checkOutput("misalign_err", misalign_err, mis_cur);
                if (valid_out && !stall && !redirect) begin
                    captures++;
                    if (expq.size() == 0) begin
                        checks++;
                        $display("[TB] FAIL scoreboard: capture of %h with empty queue", instr_out);
                    end else begin
                        a = expq.pop_front();
                        checkOutput("sb_instr", instr_out, mem_word(a));
                        checkOutput("sb_pc_out", pc_out, a + 32'd4);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got %0d/%0d", passes, checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] rpc;
        mon_en = 1'b1;
        resetDut();

        // Zero-wait memory: requests 0,4,8 on alternate cycles
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            #1;
            checkOutput("zw_req", imem_req, (i % 2 == 1) ? 1 : 0);
            if (i % 2 == 1) checkOutput("zw_addr", imem_addr, 32'(2 * (i - 1)));
        end
        repeat (3) applyStimulus(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0);
            #1;
            checkOutput("stall_valid", valid_out, 1);
            checkOutput("stall_instr", instr_out, mem_word(32'h10));
            checkOutput("stall_pc_out", pc_out, 32'h14);
            checkOutput("stall_req", imem_req, 0);
        end
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("post_stall_addr", imem_addr, 32'h14);

        // Three wait states, redirect during the second wait cycle of the fetch at 0x20
        repeat (5) applyStimulus(1'b0, 1'b0, 32'h0);
        wait_min = 3; wait_max = 3;
        applyStimulus(1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("ws_addr0", imem_addr, 32'h20);
        applyStimulus(1'b0, 1'b1, 32'h100);
        #1;
        checkOutput("ws_flush", flush_out, 1);
        checkOutput("ws_addr1", imem_addr, 32'h20);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            #1;
            checkOutput("drain_req", imem_req, 1);
            checkOutput("drain_addr", imem_addr, 32'h20);
        end
        applyStimulus(1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("target_addr", imem_addr, 32'h100);
        wait_min = 0; wait_max = 0;
        waitValid(32'h100);

        // Redirect with stall held in READY
        applyStimulus(1'b1, 1'b1, 32'h180);
        applyStimulus(1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("rs_valid", valid_out, 0);
        checkOutput("rs_addr", imem_addr, 32'h180);
        waitValid(32'h180);

        // Redirect coincident with ack in FETCH
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h300);
        #1;
        checkOutput("ra_ack", imem_ack, 1);
        applyStimulus(1'b1, 1'b0, 32'h0);
        #1;
        checkOutput("ra_valid", valid_out, 0);
        checkOutput("ra_addr", imem_addr, 32'h300);
        waitValid(32'h300);

        // Misaligned target
        applyStimulus(1'b1, 1'b1, 32'h203);
        applyStimulus(1'b1, 1'b0, 32'h0);
        #1;
        checkOutput("mis_addr", imem_addr, 32'h200);
        checkOutput("mis_flag", misalign_err, 1);
        waitValid(32'h200);

        // Wrap past the top of the address space, then async reset mid-FETCH
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFC);
        waitValid(32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b0, 32'h0);
        wait_min = 2; wait_max = 2;
        applyStimulus(1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("wrap_addr", imem_addr, 32'h0);
        checkOutput("wrap_req", imem_req, 1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_req", imem_req, 0);
        checkOutput("async_valid", valid_out, 0);
        checkOutput("async_misalign", misalign_err, 0);
        wait_min = 0; wait_max = 0;
        resetDut();
        applyStimulus(1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("restart_addr", imem_addr, 32'h0);

        // Randomized traffic
        wait_min = 0; wait_max = 3;
        for (int i = 0; i < 1500; i++) begin
            logic st;
            logic rd;
            st = ($urandom_range(99, 0) < 30);
            rd = ($urandom_range(99, 0) < 8);
            rpc = {20'h0, 10'($urandom), 2'b00};
            if ($urandom_range(9, 0) == 0) rpc = {28'hFFFF_FFF, 2'($urandom), 2'b00};
            if ($urandom_range(9, 0) == 0) rpc[1:0] = 2'($urandom_range(3, 1));
            applyStimulus(st, rd, rpc);
        end
        applyStimulus(1'b0, 1'b0, 32'h0);
        #2;
        checkOutput("capture_count_min", (captures >= 100) ? 1 : 0, 1);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
